// File: rtl/result_check_pkg.sv
// rtl/result_check_pkg.sv - shared state type, default sizes and width helpers for result_checker
package result_check_pkg;

    localparam int RC_DIM_DEFAULT       = 4;
    localparam int RC_OUT_W_DEFAULT     = 32;
    localparam int RC_MAX_MATS_DEFAULT  = 8;
    localparam int RC_LOG_DEPTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_FINISH = 2'd3
    } chk_state_t;

    // Bits needed to address every result word of a full program (at least 1).
    function automatic int rc_addr_w(input int dim, input int max_mats);
        int words;
        words = max_mats * dim * dim;
        return (words < 2) ? 1 : $clog2(words);
    endfunction

    // Bits needed to count a full program of words without wrapping (at least 1).
    function automatic int rc_cnt_w(input int dim, input int max_mats);
        int words;
        words = max_mats * dim * dim;
        return (words < 1) ? 1 : $clog2(words + 1);
    endfunction

endpackage

// File: rtl/mismatch_log_fifo.sv
// rtl/mismatch_log_fifo.sv - synchronous FIFO holding {addr, got, exp} mismatch log entries
module mismatch_log_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] in_tdata,
    input  logic             in_tvalid,
    output logic             in_tready,
    output logic [WIDTH-1:0] out_tdata,
    output logic             out_tvalid,
    input  logic             out_tready
);

    localparam int PTR_W = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign out_tvalid = (count != '0);
    // A full FIFO still takes a push when the head is popped in the same cycle.
    assign in_tready  = (count != FULL_CNT) || out_tready;
    assign do_pop     = out_tvalid && out_tready;
    assign do_push    = in_tvalid && in_tready;
    assign out_tdata  = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; clr empties the FIFO without touching storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Entry storage, written on every accepted push.
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wr_ptr] <= in_tdata;
        end
    end

endmodule

// File: rtl/result_checker.sv
// rtl/result_checker.sv - streams DUT and expected result memories, counts matches; mismatch log under RESULT_CHECKER_LOG_EN
module result_checker
    import result_check_pkg::*;
#(
    parameter int  DIM       = RC_DIM_DEFAULT,
    parameter int  OUT_W     = RC_OUT_W_DEFAULT,
    parameter int  MAX_MATS  = RC_MAX_MATS_DEFAULT,
    parameter int  LOG_DEPTH = RC_LOG_DEPTH_DEFAULT,
    localparam int ADDR_W    = rc_addr_w(DIM, MAX_MATS),
    localparam int CNT_W     = rc_cnt_w(DIM, MAX_MATS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        n,
    output logic [ADDR_W-1:0] addrO,
    input  logic [OUT_W-1:0]  dataO,
    input  logic [OUT_W-1:0]  exp_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count,
    input  logic              log_rd,
    output logic              log_valid,
    output logic [ADDR_W-1:0] log_addr,
    output logic [OUT_W-1:0]  log_got,
    output logic [OUT_W-1:0]  log_exp,
    output logic              log_ovf
);

    localparam int WORDS_PER_MAT = DIM * DIM;

    chk_state_t        state_q;
    chk_state_t        state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] last_addr_q;
    logic [ADDR_W-1:0] last_addr_c;
    int                n_eff_c;
    logic              start_acc;
    logic              cmp_valid;
    logic [ADDR_W-1:0] cmp_addr;
    logic              cmp_match;
    logic [CNT_W-1:0]  pass_cnt;
    logic [CNT_W-1:0]  fail_cnt;
    logic              done_q;
    logic              pass_q;

    // Clamp the requested matrix count and derive the final read address of the program.
    always_comb begin
        n_eff_c     = (int'(n) > MAX_MATS) ? MAX_MATS : int'(n);
        last_addr_c = '0;
        if (n_eff_c != 0) begin
            last_addr_c = ADDR_W'(n_eff_c * WORDS_PER_MAT - 1);
        end
    end

    // Starts are only honoured from IDLE, so a pulse during a check never restarts it.
    assign start_acc = start && (state_q == ST_IDLE);
    assign cmp_match = (dataO == exp_data);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: RUN walks the addresses, DRAIN absorbs the read latency of the last one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (n_eff_c == 0) ? ST_FINISH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (addr_q == last_addr_q) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN:  state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Address generator, one-cycle compare pipeline, counters and completion flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            last_addr_q <= '0;
            cmp_valid   <= 1'b0;
            cmp_addr    <= '0;
            pass_cnt    <= '0;
            fail_cnt    <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
        end else begin
            done_q    <= (state_q == ST_FINISH);
            cmp_valid <= (state_q == ST_RUN);
            cmp_addr  <= addr_q;
            if (start_acc) begin
                addr_q      <= '0;
                last_addr_q <= last_addr_c;
                pass_cnt    <= '0;
                fail_cnt    <= '0;
                pass_q      <= 1'b0;
            end else begin
                if ((state_q == ST_RUN) && (addr_q != last_addr_q)) begin
                    addr_q <= addr_q + ADDR_W'(1);
                end
                if (cmp_valid) begin
                    if (cmp_match) begin
                        pass_cnt <= pass_cnt + CNT_W'(1);
                    end else begin
                        fail_cnt <= fail_cnt + CNT_W'(1);
                    end
                end
                if (state_q == ST_FINISH) begin
                    pass_q <= (fail_cnt == '0);
                end
            end
        end
    end

    assign addrO      = addr_q;
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign pass       = pass_q;
    assign pass_count = pass_cnt;
    assign fail_count = fail_cnt;

`ifdef RESULT_CHECKER_LOG_EN
    localparam int LOG_W = ADDR_W + 2 * OUT_W;

    logic             log_push;
    logic             log_ready;
    logic             ovf_q;
    logic [LOG_W-1:0] log_entry;

    assign log_push = cmp_valid && !cmp_match;

    mismatch_log_fifo #(
        .WIDTH (LOG_W),
        .DEPTH (LOG_DEPTH)
    ) u_log_fifo (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_acc),
        .in_tdata   ({cmp_addr, dataO, exp_data}),
        .in_tvalid  (log_push),
        .in_tready  (log_ready),
        .out_tdata  (log_entry),
        .out_tvalid (log_valid),
        .out_tready (log_rd)
    );

    assign {log_addr, log_got, log_exp} = log_entry;

    // Sticky overflow: a mismatch the full log could not take, cleared by the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (start_acc) begin
            ovf_q <= 1'b0;
        end else if (log_push && !log_ready) begin
            ovf_q <= 1'b1;
        end
    end

    assign log_ovf = ovf_q;
`else
    logic log_unused;
    assign log_unused = ^{log_rd, cmp_addr, (LOG_DEPTH > 0)};

    assign log_valid = 1'b0;
    assign log_addr  = '0;
    assign log_got   = '0;
    assign log_exp   = '0;
    assign log_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_result_checker.sv
// tb/tb_result_checker.sv - scoreboard bench for result_checker against a word-level reference model
module tb_result_checker;

    localparam int DIM       = 4;
    localparam int OUT_W     = 32;
    localparam int MAX_MATS  = 8;
    localparam int LOG_DEPTH = 4;
    localparam int WORDS_MAX = MAX_MATS * DIM * DIM;
    localparam int ADDR_W    = 7;
    localparam int CNT_W     = 8;
    localparam int LOG_W     = ADDR_W + 2 * OUT_W;

    typedef struct {
        int t0;
        int words;
        int lat;
        int pcnt;
        int fcnt;
        bit pass;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [3:0]        n = '0;
    logic [ADDR_W-1:0] addrO;
    logic [OUT_W-1:0]  dataO;
    logic [OUT_W-1:0]  exp_data;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CNT_W-1:0]  pass_count;
    logic [CNT_W-1:0]  fail_count;
    logic              log_rd = 1'b0;
    logic              log_valid;
    logic [ADDR_W-1:0] log_addr;
    logic [OUT_W-1:0]  log_got;
    logic [OUT_W-1:0]  log_exp;
    logic              log_ovf;

    logic [OUT_W-1:0] dut_mem [WORDS_MAX];
    logic [OUT_W-1:0] exp_mem [WORDS_MAX];
    exp_t             exp_q[$];
    logic [LOG_W-1:0] log_q[$];
    bit               exp_ovf;
    int               cyc = 0;
    int               checks = 0;
    int               errors = 0;
    int               seq_bad = 0;

    result_checker #(
        .DIM       (DIM),
        .OUT_W     (OUT_W),
        .MAX_MATS  (MAX_MATS),
        .LOG_DEPTH (LOG_DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .n          (n),
        .addrO      (addrO),
        .dataO      (dataO),
        .exp_data   (exp_data),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .pass_count (pass_count),
        .fail_count (fail_count),
        .log_rd     (log_rd),
        .log_valid  (log_valid),
        .log_addr   (log_addr),
        .log_got    (log_got),
        .log_exp    (log_exp),
        .log_ovf    (log_ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Both result memories answer one cycle after the address.
    always @(posedge clk) begin
        dataO    <= dut_mem[addrO];
        exp_data <= exp_mem[addrO];
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, got, want);
        end
    endtask

    task automatic flip(input int a);
        dut_mem[a] = exp_mem[a] ^ (32'h1 << $urandom_range(0, 31));
    endtask

    task automatic fill(input int pct);
        for (int a = 0; a < WORDS_MAX; a++) begin
            exp_mem[a] = $urandom;
            dut_mem[a] = exp_mem[a];
            if (int'($urandom_range(0, 99)) < pct) flip(a);
        end
    endtask

    // Reference model: walk the first min(n, MAX_MATS) matrices word by word.
    task automatic build_expect(input int n_in, output exp_t e);
        int eff;
        eff    = (n_in > MAX_MATS) ? MAX_MATS : n_in;
        e.t0   = 0;
        e.words = eff * DIM * DIM;
        e.lat  = (e.words == 0) ? 1 : e.words + 2;
        e.fcnt = 0;
        log_q.delete();
        for (int a = 0; a < e.words; a++) begin
            if (dut_mem[a] !== exp_mem[a]) begin
                e.fcnt++;
                if (log_q.size() < LOG_DEPTH) log_q.push_back({ADDR_W'(a), dut_mem[a], exp_mem[a]});
            end
        end
        e.pcnt  = e.words - e.fcnt;
        e.pass  = (e.fcnt == 0);
        exp_ovf = (e.fcnt > LOG_DEPTH);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addrO"}, addrO, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_counts"}, {pass_count, fail_count}, 0);
        check({tag, "_log"}, {log_valid, log_ovf}, 0);
    endtask

    task automatic run(input int n_in, input bit poke);
        exp_t e;
        int   guard;
        build_expect(n_in, e);
        @(negedge clk);
        e.t0 = cyc + 1;
        exp_q.push_back(e);
        n     = 4'(n_in);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        if (poke) begin
            repeat (3) @(negedge clk);
            n     = 4'd1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        guard = 0;
        while (exp_q.size() != 0 && guard < e.lat + 20) begin
            @(negedge clk);
            guard++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, want done", guard);
            exp_q.delete();
        end
        @(negedge clk);
        check("held_pass", pass, e.pass);
        check("held_counts", {pass_count, fail_count}, {CNT_W'(e.pcnt), CNT_W'(e.fcnt)});
`ifdef RESULT_CHECKER_LOG_EN
        for (int i = 0; i < log_q.size(); i++) begin
            check("log_valid", log_valid, 1'b1);
            check("log_entry", {log_addr, log_got, log_exp}, log_q[i]);
            log_rd = 1'b1;
            @(posedge clk);
            #1 log_rd = 1'b0;
            @(negedge clk);
        end
        check("log_empty", log_valid, 1'b0);
        check("log_ovf", log_ovf, exp_ovf);
`else
        check("log_tied", {log_valid, log_ovf, log_addr, log_got, log_exp}, 0);
        log_rd = 1'b1;
        @(posedge clk);
        #1 log_rd = 1'b0;
        @(negedge clk);
        check("log_tied_after_rd", {log_valid, log_ovf, log_addr, log_got, log_exp}, 0);
`endif
    endtask

    // Monitor: per-cycle address/busy tracking and final result comparison on done.
    always @(negedge clk) begin : monitor
        exp_t cur;
        int   k;
        int   want_addr;
        if (!rst) begin
            if (exp_q.size() != 0 && cyc >= exp_q[0].t0) begin
                cur = exp_q[0];
                k   = cyc - cur.t0;
                if (cur.words == 0) want_addr = 0;
                else want_addr = (k < cur.words) ? k : cur.words - 1;
                if (busy !== (k < cur.lat)) seq_bad++;
                if (addrO !== ADDR_W'(want_addr)) seq_bad++;
                if (done === 1'b1) begin
                    check("done_latency", k, cur.lat);
                    check("pass", pass, cur.pass);
                    check("pass_count", pass_count, cur.pcnt);
                    check("fail_count", fail_count, cur.fcnt);
                    check("addr_busy_seq", seq_bad, 0);
                    void'(exp_q.pop_front());
                    seq_bad = 0;
                end
            end else if (done === 1'b1) begin
                check("unexpected_done", done, 1'b0);
            end
        end
    end

    initial begin : stimulus
        bit saw_done;
        fill(0);
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_reset");

        run(0, 0);

        fill(0);
        run(1, 0);

        fill(0);
        flip(5);
        flip(20);
        run(2, 0);

        fill(10);
        run(12, 1);

        fill(0);
        flip(1); flip(3); flip(6); flip(8); flip(11); flip(14);
        run(1, 0);

        fill(0);
        run(1, 0);

        fill(0);
        @(negedge clk);
        n     = 4'd2;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        check("abort_no_done", saw_done, 1'b0);
        run(2, 0);

        repeat (6) begin
            fill(int'($urandom_range(0, 30)));
            run(int'($urandom_range(0, 15)), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish by time limit, want finish");
        $fatal(1, "bench time limit reached");
    end

endmodule
